counter_bank: RTL and testbench
===============================

# counter_bank

Parametrised multi-channel counter core: the next generation of the single 32-bit counter. It provides CHANNELS independent counters of WIDTH bits, each with a per-channel prescaler, up/down direction, one-shot or auto-restart mode, sticky overflow flags, and a combined interrupt. It sits behind the peripheral's register block, which drives the configuration and action inputs and reads back count and status.

## Interface
Parameters:
- CHANNELS, 4: number of independent counters (1..16).
- WIDTH, 32: counter width in bits (2..32).
- PRESC_W, 8: prescaler compare width in bits (1..16).

Ports (index i occupies slice [i*W +: W]):
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- enable  in  CHANNELS  per-channel count enable; prescaler and count hold while low.
- auto_restart  in  CHANNELS  1 = wrap at terminal; 0 = one-shot, stop at terminal.
- down  in  CHANNELS  1 = count down from cap to 0; 0 = count up from 0 to cap.
- cap  in  CHANNELS*WIDTH  terminal value (up) / reload value (down).
- presc  in  CHANNELS*PRESC_W  tick every presc+1 enabled cycles.
- load  in  CHANNELS  one-cycle action: count <= load_val.
- load_val  in  CHANNELS*WIDTH  value applied on load.
- ovf_clear  in  CHANNELS  one-cycle action: clear ovf_sticky.
- count  out  CHANNELS*WIDTH  current count (registered).
- overflow  out  CHANNELS  one-cycle pulse on terminal event.
- ovf_sticky  out  CHANNELS  latched overflow.
- done  out  CHANNELS  one-shot channel has reached terminal and stopped.
- irq  out  1  OR of all ovf_sticky bits.

## Operation
Each channel holds a prescaler counter p[PRESC_W], count[WIDTH], done, and ovf_sticky.
- Prescaler: when enable=1 and done=0: if p == presc then p <= 0 and tick=1, else p <= p+1. presc=0 gives a tick every cycle. When enable=0 or done=1, p holds.
- Up mode, on tick: terminal when count >= cap (>= covers cap lowered below count mid-run). At terminal, overflow pulses; if auto_restart then count <= 0, else count holds and done <= 1. Otherwise count <= count+1.
- Down mode, on tick: terminal when count == 0. At terminal, overflow pulses; if auto_restart then count <= cap, else count holds at 0 and done <= 1. Otherwise count <= count-1.
- cap=0 in up mode with auto_restart: terminal on every tick; count stays 0 and overflow pulses each tick.
- load: count <= load_val, p <= 0, done <= 0. No tick or overflow is evaluated that cycle (load has priority over tick). Loading a value above cap in up mode terminates on the next tick.
- Toggling down or auto_restart mid-run takes effect at the next tick; no count adjustment.
- ovf_sticky: set by overflow; cleared by ovf_clear. If both happen in the same cycle, the set wins.
- done is cleared only by load or reset. Deasserting enable does not clear done.
- irq = |ovf_sticky (combinational from registers, glitch-free).
- Channels are fully independent; no shared state apart from irq.

## Timing
- Reset (reset=0, asynchronous): count=0, p=0, overflow=0, ovf_sticky=0, done=0, irq=0. Release is synchronous to clk; the first tick can occur no earlier than the first edge after release.
- All outputs are registered except irq (one gate level from ovf_sticky).
- load sampled at edge N: count=load_val visible after edge N.
- Terminal tick at edge N: overflow=1 for exactly the cycle after edge N; the wrapped or held count and ovf_sticky=1 update on the same edge N; irq follows in the same cycle.
- Tick period: presc+1 cycles of enable=1. p restarts from 0 after load.
- ovf_clear at edge N: ovf_sticky=0 after edge N unless overflow is also set at N.

## Test plan
- Reset mid-count: ch0 up, cap=10, presc=0, assert reset at count=5 -> all outputs 0 immediately, without waiting for clk.
- Up auto-restart: cap=3, presc=0 -> count 0,1,2,3,0,…; overflow pulses one cycle at each 3->0; ovf_sticky=1; irq=1.
- Prescaler + enable gaps: presc=2, cap=100 -> count increments every 3rd enabled cycle; enable low for 5 cycles -> count and p frozen.
- Down one-shot: down=1, auto_restart=0, load_val=2, load -> count 2,1,0, then holds; single overflow pulse; done=1; later load of 5 clears done and counting resumes.
- Simultaneous events: load and terminal tick on the same edge -> count=load_val, no overflow. ovf_clear and overflow on the same edge -> ovf_sticky stays 1.
- Parameter sweep: CHANNELS=1/4/16, WIDTH=2/32 -> all channels independent; WIDTH=2 up with cap=3 wraps 3->0 without arithmetic overflow artefacts.

Source files
------------

// File: rtl/counter_bank_if.sv
// Register-block side bundle for counter_bank: per-channel configuration and actions in,
// count and status out. Per-channel fields are packed, channel i at [i*W +: W].
interface counter_bank_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PRESC_W  = 8
);
    logic [CHANNELS-1:0]         enable;
    logic [CHANNELS-1:0]         auto_restart;
    logic [CHANNELS-1:0]         down;
    logic [CHANNELS*WIDTH-1:0]   cap;
    logic [CHANNELS*PRESC_W-1:0] presc;
    logic [CHANNELS-1:0]         load;
    logic [CHANNELS*WIDTH-1:0]   load_val;
    logic [CHANNELS-1:0]         ovf_clear;
    logic [CHANNELS*WIDTH-1:0]   count;
    logic [CHANNELS-1:0]         overflow;
    logic [CHANNELS-1:0]         ovf_sticky;
    logic [CHANNELS-1:0]         done;
    logic                        irq;

    modport master (
        output enable, auto_restart, down, cap, presc, load, load_val, ovf_clear,
        input  count, overflow, ovf_sticky, done, irq
    );

    modport slave (
        input  enable, auto_restart, down, cap, presc, load, load_val, ovf_clear,
        output count, overflow, ovf_sticky, done, irq
    );
endinterface

// File: rtl/counter_bank.sv
// Multi-channel counter core: per-channel prescaler, up/down, one-shot or auto-restart,
// sticky overflow, and an interrupt that ORs all sticky flags.
module counter_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PRESC_W  = 8
) (
    input  logic          clk,
    input  logic          reset,
    counter_bank_if.slave bus
);

    logic [CHANNELS-1:0][PRESC_W-1:0] p_q, p_d;
    logic [CHANNELS-1:0][WIDTH-1:0]   count_q, count_d;
    logic [CHANNELS-1:0]              done_q, done_d;
    logic [CHANNELS-1:0]              ovf_q, ovf_d;
    logic [CHANNELS-1:0]              sticky_q, sticky_d;

    always_comb begin
        p_d      = p_q;
        count_d  = count_q;
        done_d   = done_q;
        ovf_d    = '0;
        sticky_d = sticky_q;
        for (int i = 0; i < CHANNELS; i++) begin
            // load wins over any tick evaluated on the same edge
            if (bus.load[i]) begin
                count_d[i] = bus.load_val[i*WIDTH +: WIDTH];
                p_d[i]     = '0;
                done_d[i]  = 1'b0;
            end else if (bus.enable[i] && !done_q[i]) begin
                if (p_q[i] == bus.presc[i*PRESC_W +: PRESC_W]) begin
                    p_d[i] = '0;
                    if (bus.down[i]) begin
                        if (count_q[i] == '0) begin
                            ovf_d[i] = 1'b1;
                            if (bus.auto_restart[i]) count_d[i] = bus.cap[i*WIDTH +: WIDTH];
                            else                     done_d[i]  = 1'b1;
                        end else begin
                            count_d[i] = count_q[i] - WIDTH'(1);
                        end
                    end else begin
                        // >= so a cap lowered below the running count still terminates
                        if (count_q[i] >= bus.cap[i*WIDTH +: WIDTH]) begin
                            ovf_d[i] = 1'b1;
                            if (bus.auto_restart[i]) count_d[i] = '0;
                            else                     done_d[i]  = 1'b1;
                        end else begin
                            count_d[i] = count_q[i] + WIDTH'(1);
                        end
                    end
                end else begin
                    p_d[i] = p_q[i] + PRESC_W'(1);
                end
            end
            // a new overflow beats a simultaneous clear
            if (ovf_d[i])              sticky_d[i] = 1'b1;
            else if (bus.ovf_clear[i]) sticky_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q      <= '0;
            count_q  <= '0;
            done_q   <= '0;
            ovf_q    <= '0;
            sticky_q <= '0;
        end else begin
            p_q      <= p_d;
            count_q  <= count_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.overflow   = ovf_q;
    assign bus.ovf_sticky = sticky_q;
    assign bus.done       = done_q;
    assign bus.irq        = |sticky_q;

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: a per-channel behavioural model checked every cycle,
// plus literal expectations on a wide instance and a narrow (WIDTH=2) instance.
module tb_counter_bank;

    localparam int unsigned C   = 4;
    localparam int unsigned W   = 32;
    localparam int unsigned PW  = 8;
    localparam int unsigned CB  = 2;
    localparam int unsigned WB  = 2;
    localparam int unsigned PWB = 1;

    logic clk;
    logic reset;
    bit   checking;
    int   n_cmp;
    int   n_err;

    counter_bank_if #(.CHANNELS(C),  .WIDTH(W),  .PRESC_W(PW))  bus  ();
    counter_bank_if #(.CHANNELS(CB), .WIDTH(WB), .PRESC_W(PWB)) busb ();

    counter_bank #(.CHANNELS(C), .WIDTH(W), .PRESC_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    counter_bank #(.CHANNELS(CB), .WIDTH(WB), .PRESC_W(PWB)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (busb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint cnt_a(int i);
        return longint'(bus.count[i*W +: W]);
    endfunction

    function automatic longint cnt_b(int i);
        return longint'(busb.count[i*WB +: WB]);
    endfunction

    // Behavioural model of the wide instance: prescaler as a modular phase, count as integer
    typedef struct {
        int     p;
        longint cnt;
        bit     done;
        bit     sticky;
        bit     ovf;
    } ch_t;

    ch_t m [C];

    function automatic ch_t model_next(ch_t s, int i);
        ch_t    n;
        longint capv;
        int     period;
        bit     terminal;
        n      = s;
        n.ovf  = 1'b0;
        capv   = longint'(bus.cap[i*W +: W]);
        period = int'(bus.presc[i*PW +: PW]) + 1;
        if (bus.load[i]) begin
            n.cnt  = longint'(bus.load_val[i*W +: W]);
            n.p    = 0;
            n.done = 1'b0;
        end else if (bus.enable[i] && !s.done) begin
            n.p = (s.p + 1) % period;
            if (n.p == 0) begin
                terminal = bus.down[i] ? (s.cnt == 0) : (s.cnt >= capv);
                if (terminal) begin
                    n.ovf = 1'b1;
                    if (bus.auto_restart[i]) n.cnt = bus.down[i] ? capv : 0;
                    else                     n.done = 1'b1;
                end else begin
                    n.cnt = bus.down[i] ? s.cnt - 1 : s.cnt + 1;
                end
            end
        end
        if (n.ovf)                 n.sticky = 1'b1;
        else if (bus.ovf_clear[i]) n.sticky = 1'b0;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < C; i++) m[i] <= '{default: 0};
        end else begin
            for (int i = 0; i < C; i++) m[i] <= model_next(m[i], i);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            bit any_sticky;
            any_sticky = 1'b0;
            for (int i = 0; i < C; i++) begin
                chk($sformatf("model count[%0d]", i), cnt_a(i), m[i].cnt);
                chk($sformatf("model overflow[%0d]", i), longint'(bus.overflow[i]),
                    longint'(m[i].ovf));
                chk($sformatf("model ovf_sticky[%0d]", i), longint'(bus.ovf_sticky[i]),
                    longint'(m[i].sticky));
                chk($sformatf("model done[%0d]", i), longint'(bus.done[i]),
                    longint'(m[i].done));
                any_sticky |= m[i].sticky;
            end
            chk("model irq", longint'(bus.irq), longint'(any_sticky));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        checking = 1'b0;
        reset    = 1'b0;
        bus.enable = '0; bus.auto_restart = '0; bus.down = '0; bus.cap = '0;
        bus.presc = '0; bus.load = '0; bus.load_val = '0; bus.ovf_clear = '0;
        busb.enable = '0; busb.auto_restart = '0; busb.down = '0; busb.cap = '0;
        busb.presc = '0; busb.load = '0; busb.load_val = '0; busb.ovf_clear = '0;

        step(2);
        checking = 1'b1;
        chk("reset count0", cnt_a(0), 0);
        chk("reset irq", longint'(bus.irq), 0);

        // Reset mid-count
        reset = 1'b1;
        bus.auto_restart[0] = 1'b1;
        bus.cap[0*W +: W] = 10;
        bus.enable[0] = 1'b1;
        step(5);
        chk("precount count0", cnt_a(0), 5);
        #3 reset = 1'b0;
        #1;
        chk("async reset count0", cnt_a(0), 0);
        chk("async reset done", longint'(bus.done), 0);
        chk("async reset sticky", longint'(bus.ovf_sticky), 0);
        step(1);
        reset = 1'b1;

        // Up auto-restart cap=3 on ch0; prescaler 2 with enable gaps on ch1
        bus.cap[0*W +: W] = 3;
        bus.auto_restart[1] = 1'b1;
        bus.cap[1*W +: W] = 100;
        bus.presc[1*PW +: PW] = 2;
        bus.enable[1] = 1'b1;
        step(3);
        chk("up count0 at 3", cnt_a(0), 3);
        chk("presc count1 first tick", cnt_a(1), 1);
        step(1);
        chk("wrap count0", cnt_a(0), 0);
        chk("wrap overflow0", longint'(bus.overflow[0]), 1);
        chk("wrap sticky0", longint'(bus.ovf_sticky[0]), 1);
        chk("wrap irq", longint'(bus.irq), 1);
        step(1);
        chk("after wrap count0", cnt_a(0), 1);
        chk("after wrap overflow0", longint'(bus.overflow[0]), 0);
        step(1);
        chk("presc count1 second tick", cnt_a(1), 2);
        step(1);
        bus.enable[1] = 1'b0;
        step(5);
        chk("frozen count1", cnt_a(1), 2);
        bus.enable[1] = 1'b1;
        step(2);
        chk("resumed count1", cnt_a(1), 3);

        // cap=0 up auto-restart: overflow every tick, count pinned at 0
        bus.cap[1*W +: W] = 0;
        bus.presc[1*PW +: PW] = 0;
        step(1);
        chk("cap0 count1", cnt_a(1), 0);
        chk("cap0 overflow1 a", longint'(bus.overflow[1]), 1);
        step(1);
        chk("cap0 overflow1 b", longint'(bus.overflow[1]), 1);
        bus.enable[1] = 1'b0;

        // Down one-shot on ch2
        bus.down[2] = 1'b1;
        bus.cap[2*W +: W] = 7;
        bus.load_val[2*W +: W] = 2;
        bus.load[2] = 1'b1;
        bus.enable[2] = 1'b1;
        step(1);
        chk("down load count2", cnt_a(2), 2);
        bus.load[2] = 1'b0;
        step(2);
        chk("down count2 at 0", cnt_a(2), 0);
        chk("down no early ovf2", longint'(bus.overflow[2]), 0);
        step(1);
        chk("down terminal ovf2", longint'(bus.overflow[2]), 1);
        chk("down done2", longint'(bus.done[2]), 1);
        step(1);
        chk("down held count2", cnt_a(2), 0);
        chk("down single pulse ovf2", longint'(bus.overflow[2]), 0);
        bus.enable[2] = 1'b0;
        step(1);
        chk("done survives enable low", longint'(bus.done[2]), 1);
        bus.load_val[2*W +: W] = 5;
        bus.load[2] = 1'b1;
        bus.enable[2] = 1'b1;
        step(1);
        chk("reload count2", cnt_a(2), 5);
        chk("reload clears done2", longint'(bus.done[2]), 0);
        bus.load[2] = 1'b0;
        step(1);
        chk("resume count2", cnt_a(2), 4);

        // Simultaneous events on ch3
        bus.auto_restart[3] = 1'b1;
        bus.cap[3*W +: W] = 2;
        bus.enable[3] = 1'b1;
        step(2);
        chk("ch3 at cap", cnt_a(3), 2);
        bus.load_val[3*W +: W] = 9;
        bus.load[3] = 1'b1;
        step(1);
        chk("load beats tick count3", cnt_a(3), 9);
        chk("load beats tick ovf3", longint'(bus.overflow[3]), 0);
        bus.load[3] = 1'b0;
        step(1);
        chk("above cap terminates", cnt_a(3), 0);
        chk("above cap ovf3", longint'(bus.overflow[3]), 1);
        bus.ovf_clear[3] = 1'b1;
        step(1);
        chk("clear sticky3", longint'(bus.ovf_sticky[3]), 0);
        bus.ovf_clear[3] = 1'b0;
        step(1);
        bus.ovf_clear[3] = 1'b1;
        step(1);
        chk("set beats clear sticky3", longint'(bus.ovf_sticky[3]), 1);
        bus.ovf_clear[3] = 1'b0;
        bus.down[3] = 1'b1;
        step(1);
        chk("toggle down reload count3", cnt_a(3), 2);
        chk("toggle down ovf3", longint'(bus.overflow[3]), 1);

        bus.enable = '0;
        bus.ovf_clear = '1;
        step(1);
        chk("irq cleared", longint'(bus.irq), 0);
        bus.ovf_clear = '0;

        // Narrow instance: WIDTH=2 wraps 3->0; ch1 ticks every 2nd cycle
        busb.auto_restart = 2'b11;
        busb.cap = 4'b1111;
        busb.presc = 2'b10;
        busb.enable = 2'b11;
        step(3);
        chk("w2 count0 at 3", cnt_b(0), 3);
        chk("w2 count1 at 1", cnt_b(1), 1);
        step(1);
        chk("w2 wrap count0", cnt_b(0), 0);
        chk("w2 wrap ovf0", longint'(busb.overflow[0]), 1);
        chk("w2 count1 at 2", cnt_b(1), 2);
        step(2);
        chk("w2 count0 at 2", cnt_b(0), 2);
        chk("w2 count1 at 3", cnt_b(1), 3);
        step(2);
        chk("w2 both wrapped", cnt_b(0) + cnt_b(1), 0);
        chk("w2 both ovf", longint'(busb.overflow), 3);
        chk("w2 irq", longint'(busb.irq), 1);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
